ap_s: RTL and testbench
=======================

# ap_s

Bit-serial associative processor (AP) core for the Arty-100T FPGA build. It holds 512 rows of three 8-bit CAM columns (A, B, C), duplicated in two selectable internal banks. In memory mode the host reads and writes individual words. In AP mode the core runs a row-parallel compare/write lookup-table sequence that computes C = f(A, B) for every row of one bank, then raises a completion flag.

## Interface
Parameters:
- WORD_SIZE, 8: bits per column word.
- CELL_QUANT, 512: rows per bank.
- ADDR_W, 10: address width, equal to clogb2(CELL_QUANT), i.e. bit count of 512.

Ports (one clock; reset asynchronous, active-high):
- CLK100MHZ, input, 1: sole clock, rising edge.
- rst, input, 1: asynchronous active-high reset.
- addr_in, input, ADDR_W: row address.
- data_in, input, 8: write data.
- ap_mode, input, 1: 0 = memory mode, 1 = request/run AP operation.
- cmd, input, 3: AP operation code.
- sel_col, input, 2: column select. 0 = A, 1 = B, 2 = C, 3 = flag vector.
- sel_internal_col, input, 1: bank select (0 or 1).
- write_en, input, 1: memory write strobe.
- read_en, input, 1: memory read strobe.
- data_out, output, 8: registered read data.
- ap_state_irq, output, 1: AP operation complete.

## Operation
- **Storage:** A/B/C[bank][row][7:0]. A per-row flag vector F[511:0] and a per-row tag vector T[511:0] are shared by both banks.
- **Reset (rst=1):**
  - FSM goes to IDLE; data_out=0; ap_state_irq=0; F=0; T=0.
  - All A/B/C cells of the bank selected by sel_internal_col clear to 0. The other bank retains its contents.
- **Memory write:** in IDLE with ap_mode=0 and write_en=1, the selected column word at row addr_in of bank sel_internal_col takes data_in.
  - sel_col=3 writes are ignored.
  - Rows ≥512 are ignored.
- **Memory read:** in IDLE with ap_mode=0 and read_en=1, data_out takes the selected word.
  - Rows ≥512 return 0.
  - sel_col=3 behaves as described in Configuration.
  - If read_en and write_en are both high, the read returns the pre-write data.
  - data_out holds its value when there is no read.
- **AP FSM states:** IDLE, INIT, COMPARE, WRITE, DONE.
  - IDLE→INIT when ap_mode=1. INIT latches cmd and bank, clears F, and sets bit=0, pass=0.
  - COMPARE: T[r] = (A[r][bit], B[r][bit], F[r]) == pass[2:0].
  - WRITE: for each row with T[r]=1, C[r][bit] = LUT_c(pass) and Fnext[r] = LUT_f(pass).
  - WRITE then advances pass. After pass 7, F takes Fnext, pass resets to 0 and bit increments. After bit 7 the FSM goes to DONE.
  - DONE: ap_state_irq=1 until ap_mode=0, then IDLE.
  - write_en and read_en are ignored outside IDLE.
- **cmd truth tables** (inputs a, b, f):
  - 0 ADD: c = a^b^f; f' = majority(a, b, f).
  - 1 SUB (C = A−B): c = a^b^f; f' = (~a&b) | (~(a^b)&f).
  - 2 AND, 3 OR, 4 XOR: c = a op b; f' = 0.
  - 5 NOT: c = ~a.
  - 6 COPY: c = a.
  - 7 CLEAR: c = 0.
  - For cmd 5–7, f' = 0.
- **Arithmetic:** results are modulo 256. The final F holds carry-out (ADD) or borrow-out (SUB) per row.

## Timing
- Memory write: takes effect on the sampling edge and is visible to a read on the next cycle.
- Memory read: 1-cycle latency. data_out is valid after the edge that samples read_en.
- AP start: edge n samples ap_mode=1 in IDLE.
  - 128 COMPARE/WRITE cycles: 8 bits × 8 passes × 2.
  - ap_state_irq rises after edge n+129.
- ap_mode must stay high until DONE. Dropping it mid-run does not abort the operation; the FSM goes DONE→IDLE one cycle after irq.
- Asynchronous rst mid-run aborts: IDLE, irq=0, selected bank cleared.

## Configuration
- AP_S_FLAG_READ_EN defined: a read with sel_col=3 returns F[{addr_in[5:0],3'b000} +: 8]. Bit j of the result is the flag of row 8·addr_in[5:0]+j.
- Undefined: sel_col=3 reads return 0x00, and the F read mux is not built.

## Test plan
- Reset bank 0, then bank 1 (sel_internal_col=1, rst pulse), then read all columns of row 0 in both banks → 0x00.
- Write A[0]=10, B[0]=10, C[0]=10 in bank 0, then read each → 10 after 1 cycle. Bank 1 row 0 still reads 0.
- A[0]=10, B[0]=10, A[511]=200, B[511]=100; cmd=0, ap_mode=1 → irq at edge n+129. Results: C[0]=20, C[511]=44. With the macro, sel_col=3 at addr 63 → 0x80.
- A[5]=10, B[5]=20, cmd=1 → C[5]=246, borrow F[5]=1. cmd=4 with A=0xF0, B=0x3C → C=0xCC.
- During a run, write_en=1 to C[0]=99 → ignored. After ap_mode=0, FSM returns to IDLE, irq=0, and C[0] keeps its AP result.
- Assert rst at cycle 40 of a run → irq stays 0, FSM IDLE. Row 0 of the selected bank reads 0x00 for A, B and C.

Source files
------------

// File: rtl/ap_s.sv
// ap_s: bit-serial associative processor, 512 rows x {A,B,C} x 2 banks, C = f(A,B) via compare/write LUT passes.
// Optional build macro AP_S_FLAG_READ_EN exposes the flag vector on sel_col=3 reads.

module ap_s_row #(
    parameter int WORD_SIZE = 8,
    parameter int BIT_W     = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    rst_bank,
    input  logic                          we,
    input  logic                          wr_bank,
    input  logic [1:0]                    wr_col,
    input  logic [WORD_SIZE-1:0]          wr_data,
    input  logic                          ap_cmp,
    input  logic                          ap_wr,
    input  logic                          ap_bank,
    input  logic [BIT_W-1:0]              bit_idx,
    input  logic [2:0]                    pass,
    input  logic                          lut_c,
    input  logic                          lut_f,
    input  logic                          f_cur,
    output logic                          f_new,
    output logic [1:0][WORD_SIZE-1:0]     a_q,
    output logic [1:0][WORD_SIZE-1:0]     b_q,
    output logic [1:0][WORD_SIZE-1:0]     c_q
);
    logic t_q, fn_q;

    // Each bank has its own reset so a reset pulse only wipes the selected bank.
    for (genvar k = 0; k < 2; k++) begin : g_bank
        logic [WORD_SIZE-1:0] a_r, b_r, c_r;

        always_ff @(posedge clk or posedge rst_bank[k]) begin
            if (rst_bank[k]) begin
                a_r <= '0;
                b_r <= '0;
                c_r <= '0;
            end else begin
                if (we && wr_bank == 1'(k)) begin
                    case (wr_col)
                        2'd0:    a_r <= wr_data;
                        2'd1:    b_r <= wr_data;
                        2'd2:    c_r <= wr_data;
                        default: ;
                    endcase
                end
                if (ap_wr && t_q && ap_bank == 1'(k))
                    c_r[bit_idx] <= lut_c;
            end
        end

        assign a_q[k] = a_r;
        assign b_q[k] = b_r;
        assign c_q[k] = c_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q  <= 1'b0;
            fn_q <= 1'b0;
        end else begin
            if (ap_cmp)
                t_q <= ({a_q[ap_bank][bit_idx], b_q[ap_bank][bit_idx], f_cur} == pass);
            if (ap_wr && t_q)
                fn_q <= lut_f;
        end
    end

    // Every row matches exactly one of the 8 passes per bit, so fn_q is always fresh by pass 7.
    assign f_new = t_q ? lut_f : fn_q;
endmodule

module ap_s #(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 512,
    parameter int ADDR_W     = 10
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    addr_in,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 ap_mode,
    input  logic [2:0]           cmd,
    input  logic [1:0]           sel_col,
    input  logic                 sel_internal_col,
    input  logic                 write_en,
    input  logic                 read_en,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 ap_state_irq
);
    localparam int RW    = $clog2(CELL_QUANT);
    localparam int BIT_W = $clog2(WORD_SIZE);
    localparam logic [ADDR_W-1:0] ROWS = ADDR_W'(CELL_QUANT);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_CMP, S_WR, S_DONE} state_t;

    state_t                                   state_q, state_d;
    logic [2:0]                               cmd_q, pass_q;
    logic                                     bank_q;
    logic [BIT_W-1:0]                         bit_q;
    logic [CELL_QUANT-1:0]                    f_q, f_new;
    logic [CELL_QUANT-1:0][1:0][WORD_SIZE-1:0] a_all, b_all, c_all;
    logic [1:0]                               rst_bank;
    logic [RW-1:0]                            row;
    logic [WORD_SIZE-1:0]                     rd_word;
    logic mem_ok, mem_wr, mem_rd, ap_init, ap_cmp, ap_wr, row_ok, last_pass, last_bit, lut_c, lut_f;

    assign rst_bank  = {rst & sel_internal_col, rst & ~sel_internal_col};
    assign row       = addr_in[RW-1:0];
    assign row_ok    = addr_in < ROWS;
    assign last_pass = pass_q == 3'd7;
    assign last_bit  = bit_q == BIT_W'(WORD_SIZE - 1);

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ap_mode) state_d = S_INIT;
            S_INIT:  state_d = S_CMP;
            S_CMP:   state_d = S_WR;
            S_WR:    state_d = (last_pass && last_bit) ? S_DONE : S_CMP;
            S_DONE:  if (!ap_mode) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_ok       = (state_q == S_IDLE) && !ap_mode;
        mem_wr       = mem_ok && write_en && row_ok && (sel_col != 2'd3);
        mem_rd       = mem_ok && read_en;
        ap_init      = state_q == S_INIT;
        ap_cmp       = state_q == S_CMP;
        ap_wr        = state_q == S_WR;
        ap_state_irq = state_q == S_DONE;
    end

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            cmd_q  <= '0;
            bank_q <= 1'b0;
            bit_q  <= '0;
            pass_q <= '0;
            f_q    <= '0;
        end else begin
            if (ap_init) begin
                cmd_q  <= cmd;
                bank_q <= sel_internal_col;
                bit_q  <= '0;
                pass_q <= '0;
                f_q    <= '0;
            end
            if (ap_wr) begin
                pass_q <= pass_q + 3'd1;
                if (last_pass) begin
                    bit_q <= bit_q + BIT_W'(1);
                    f_q   <= f_new;
                end
            end
        end
    end

    // Pass number encodes the matched (a, b, f) triple.
    always_comb begin
        logic a, b, f;
        a     = pass_q[2];
        b     = pass_q[1];
        f     = pass_q[0];
        lut_c = 1'b0;
        lut_f = 1'b0;
        case (cmd_q)
            3'd0: begin lut_c = a ^ b ^ f; lut_f = (a & b) | (a & f) | (b & f); end
            3'd1: begin lut_c = a ^ b ^ f; lut_f = (~a & b) | (~(a ^ b) & f); end
            3'd2: lut_c = a & b;
            3'd3: lut_c = a | b;
            3'd4: lut_c = a ^ b;
            3'd5: lut_c = ~a;
            3'd6: lut_c = a;
            default: lut_c = 1'b0;
        endcase
    end

    for (genvar r = 0; r < CELL_QUANT; r++) begin : g_row
        ap_s_row #(.WORD_SIZE(WORD_SIZE), .BIT_W(BIT_W)) u_row (
            .clk      (CLK100MHZ),
            .rst      (rst),
            .rst_bank (rst_bank),
            .we       (mem_wr && (row == RW'(r))),
            .wr_bank  (sel_internal_col),
            .wr_col   (sel_col),
            .wr_data  (data_in),
            .ap_cmp   (ap_cmp),
            .ap_wr    (ap_wr),
            .ap_bank  (bank_q),
            .bit_idx  (bit_q),
            .pass     (pass_q),
            .lut_c    (lut_c),
            .lut_f    (lut_f),
            .f_cur    (f_q[r]),
            .f_new    (f_new[r]),
            .a_q      (a_all[r]),
            .b_q      (b_all[r]),
            .c_q      (c_all[r])
        );
    end

`ifdef AP_S_FLAG_READ_EN
    logic [RW-1:0] flag_base;
    assign flag_base = {addr_in[RW-4:0], 3'b000};
`endif

    always_comb begin
        rd_word = '0;
        if (row_ok) begin
            case (sel_col)
                2'd0: rd_word = a_all[row][sel_internal_col];
                2'd1: rd_word = b_all[row][sel_internal_col];
                2'd2: rd_word = c_all[row][sel_internal_col];
                default: begin
`ifdef AP_S_FLAG_READ_EN
                    rd_word = f_q[flag_base +: WORD_SIZE];
`else
                    rd_word = '0;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst)         data_out <= '0;
        else if (mem_rd) data_out <= rd_word;
    end
endmodule

// File: tb/tb_ap_s.sv
// Scoreboard bench for ap_s: reads push expected words, the cycle after each read pops and compares.
module tb_ap_s;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] addr_in;
    logic [7:0] data_in;
    logic       ap_mode;
    logic [2:0] cmd;
    logic [1:0] sel_col;
    logic       sel_internal_col, write_en, read_en;
    logic [7:0] data_out;
    logic       ap_state_irq;

    int         n_cmp = 0, n_err = 0;
    int         lat;
    logic [7:0] exp_q[$];
    string      tag_q[$];
    logic [7:0] flag_exp;

    always #5 clk = ~clk;

    ap_s dut (
        .CLK100MHZ        (clk),
        .rst              (rst),
        .addr_in          (addr_in),
        .data_in          (data_in),
        .ap_mode          (ap_mode),
        .cmd              (cmd),
        .sel_col          (sel_col),
        .sel_internal_col (sel_internal_col),
        .write_en         (write_en),
        .read_en          (read_en),
        .data_out         (data_out),
        .ap_state_irq     (ap_state_irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic wr(input bit bk, input logic [1:0] col, input logic [9:0] a, input logic [7:0] d);
        sel_internal_col = bk; sel_col = col; addr_in = a; data_in = d; write_en = 1'b1;
        @(posedge clk); #1;
        write_en = 1'b0;
    endtask

    task automatic rd(input bit bk, input logic [1:0] col, input logic [9:0] a, input logic [7:0] exp, input string tag);
        logic [7:0] e;
        string      t;
        sel_internal_col = bk; sel_col = col; addr_in = a; read_en = 1'b1;
        exp_q.push_back(exp); tag_q.push_back(tag);
        @(posedge clk); #1;
        read_en = 1'b0;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, data_out, e);
    endtask

    // lat = edges from the ap_mode=1 sampling edge (counted as 1) to irq, 0 if none within budget.
    task automatic run_ap(input logic [2:0] c, input bit bk, input int drop_at, input int rst_at, output int l);
        logic [7:0] held;
        l = 0;
        held = data_out;
        cmd = c; sel_internal_col = bk; ap_mode = 1'b1;
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk); #1;
            if (write_en) begin
                write_en = 1'b0; read_en = 1'b0;
                chk("run_rd_ignored", data_out, held);
            end
            if (ap_state_irq) begin l = e; break; end
            if (e == drop_at) begin
                ap_mode = 1'b0; write_en = 1'b1; read_en = 1'b1;
                sel_col = 2'd2; addr_in = 10'd0; data_in = 8'd99;
            end
            if (e == rst_at) begin
                ap_mode = 1'b0; rst = 1'b1; #2; rst = 1'b0;
            end
        end
        ap_mode = 1'b0;
        @(posedge clk); #1;
        chk("irq_clear", ap_state_irq, 0);
    endtask

    initial begin
        rst = 1'b1; addr_in = '0; data_in = '0; ap_mode = 1'b0; cmd = '0;
        sel_col = '0; sel_internal_col = 1'b0; write_en = 1'b0; read_en = 1'b0;
        #12 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_dout", data_out, 0);
        chk("rst_irq", ap_state_irq, 0);
        sel_internal_col = 1'b1; rst = 1'b1; #2; rst = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < 3; c++)
                rd(1'(b), 2'(c), 10'd0, 8'd0, "rst_row0");

        // memory mode
        wr(0, 2'd0, 10'd0, 8'd10);
        wr(0, 2'd1, 10'd0, 8'd10);
        wr(0, 2'd2, 10'd0, 8'd10);
        rd(0, 2'd0, 10'd0, 8'd10, "rd_a0");
        rd(0, 2'd1, 10'd0, 8'd10, "rd_b0");
        rd(0, 2'd2, 10'd0, 8'd10, "rd_c0");
        rd(1, 2'd0, 10'd0, 8'd0, "bank1_a0");
        @(posedge clk); #1;
        chk("dout_hold", data_out, 0);
        wr(0, 2'd0, 10'd512, 8'h55);
        wr(0, 2'd3, 10'd0, 8'h77);
        rd(0, 2'd0, 10'd0, 8'd10, "oob_wr_alias");
        rd(0, 2'd0, 10'd512, 8'd0, "oob_rd");
        wr(0, 2'd0, 10'd1, 8'h33);
        write_en = 1'b1; data_in = 8'h44;
        rd(0, 2'd0, 10'd1, 8'h33, "rd_wr_pre");
        write_en = 1'b0;
        rd(0, 2'd0, 10'd1, 8'h44, "rd_wr_post");

        // ADD
        wr(0, 2'd0, 10'd511, 8'd200);
        wr(0, 2'd1, 10'd511, 8'd100);
        run_ap(3'd0, 0, 0, 0, lat);
        chk("add_latency", lat, 130);
        rd(0, 2'd2, 10'd0, 8'd20, "add_c0");
        rd(0, 2'd2, 10'd511, 8'd44, "add_c511");
`ifdef AP_S_FLAG_READ_EN
        flag_exp = 8'h80;
`else
        flag_exp = 8'h00;
`endif
        rd(0, 2'd3, 10'd63, flag_exp, "add_carry");

        // SUB
        wr(0, 2'd0, 10'd5, 8'd10);
        wr(0, 2'd1, 10'd5, 8'd20);
        run_ap(3'd1, 0, 0, 0, lat);
        chk("sub_latency", lat, 130);
        rd(0, 2'd2, 10'd5, 8'd246, "sub_c5");
        rd(0, 2'd2, 10'd0, 8'd0, "sub_c0");
        rd(0, 2'd2, 10'd511, 8'd100, "sub_c511");
`ifdef AP_S_FLAG_READ_EN
        flag_exp = 8'h20;
`else
        flag_exp = 8'h00;
`endif
        rd(0, 2'd3, 10'd0, flag_exp, "sub_borrow");

        // XOR with a mid-run ap_mode drop plus write/read attempts
        wr(0, 2'd0, 10'd0, 8'hF0);
        wr(0, 2'd1, 10'd0, 8'h3C);
        rd(0, 2'd0, 10'd511, 8'd200, "pre_xor_a511");
        run_ap(3'd4, 0, 20, 0, lat);
        chk("xor_latency", lat, 130);
        rd(0, 2'd2, 10'd0, 8'hCC, "xor_c0");
        rd(0, 2'd2, 10'd511, 8'hAC, "xor_c511");

        // AND in bank 1 leaves bank 0 alone
        wr(1, 2'd0, 10'd0, 8'd7);
        wr(1, 2'd1, 10'd0, 8'd3);
        run_ap(3'd2, 1, 0, 0, lat);
        chk("and_latency", lat, 130);
        rd(1, 2'd2, 10'd0, 8'd3, "and_c0_b1");
        rd(0, 2'd2, 10'd0, 8'hCC, "and_keep_b0");

        // reset at cycle 40 of a bank-0 run
        run_ap(3'd0, 0, 0, 40, lat);
        chk("rst_abort_irq", lat, 0);
        rd(0, 2'd0, 10'd0, 8'd0, "abort_a0");
        rd(0, 2'd1, 10'd0, 8'd0, "abort_b0");
        rd(0, 2'd2, 10'd0, 8'd0, "abort_c0");
        rd(1, 2'd0, 10'd0, 8'd7, "abort_keep_b1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
